// File: rtl/polar_encoder.sv
// Polar encoder: K serial info bits -> N-bit codeword x = u * F^(kron n), one butterfly stage per clock.
// Optional BPSK symbol output enabled by defining BPSK_MAP_EN.
module polar_encoder #(
  parameter int                      N_LOG       = 3,
  parameter int                      K           = 4,
  parameter logic [(1<<N_LOG)-1:0]   FROZEN_MASK = 8'h17,
  parameter int                      BIT_N       = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_bit,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [(1<<N_LOG)-1:0]      out_code,
`ifdef BPSK_MAP_EN
  output logic [(1<<N_LOG)*BIT_N-1:0] out_sym,
`endif
  output logic                       busy
);

  localparam int N  = 1 << N_LOG;
  localparam int CW = $clog2(K + 1);
  localparam int SW = $clog2(N_LOG + 1);

  if (K != N - $countones(FROZEN_MASK) || BIT_N < 2) begin : g_bad_param
    $error("polar_encoder: K must equal N - popcount(FROZEN_MASK) and BIT_N must be >= 2");
  end

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_ENCODE,
    ST_OUTPUT
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   info_cnt_q, info_cnt_d;
  logic [SW-1:0]   stage_cnt_q, stage_cnt_d;
  logic [N-1:0]    x_q, x_d;
  logic [N-1:0]    out_code_q, out_code_d;
  logic            out_valid_q, out_valid_d;
  int              rank;

`ifdef BPSK_MAP_EN
  localparam logic [BIT_N-1:0] SYM_POS = BIT_N'(2 ** (BIT_N - 2));
  localparam logic [BIT_N-1:0] SYM_NEG = BIT_N'(-(2 ** (BIT_N - 2)));
  logic [N*BIT_N-1:0] out_sym_q, out_sym_d;
`endif

  // NOTE: every always_comb output is given its hold value first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_d     = state_q;
    info_cnt_d  = info_cnt_q;
    stage_cnt_d = stage_cnt_q;
    x_d         = x_q;
    out_code_d  = out_code_q;
    out_valid_d = out_valid_q;
    rank        = 0;
`ifdef BPSK_MAP_EN
    out_sym_d   = out_sym_q;
`endif
    unique case (state_q)
      ST_LOAD: begin
        if (in_valid) begin
          // The n-th accepted bit lands on the n-th unfrozen index, ascending.
          for (int i = 0; i < N; i++) begin
            if (!FROZEN_MASK[i]) begin
              if (rank == int'(info_cnt_q)) x_d[i] = in_bit;
              rank++;
            end
          end
          if (int'(info_cnt_q) == K - 1) begin
            info_cnt_d = '0;
            state_d    = ST_ENCODE;
          end else begin
            info_cnt_d = info_cnt_q + CW'(1);
          end
        end
      end
      ST_ENCODE: begin
        for (int s = 0; s < N_LOG; s++) begin
          if (int'(stage_cnt_q) == s) begin
            for (int i = 0; i < N; i++) begin
              // i has bit s clear, so i | 2^s is i + 2^s and stays in range.
              if (((i >> s) & 1) == 0) x_d[i] = x_q[i] ^ x_q[i | (1 << s)];
            end
          end
        end
        if (int'(stage_cnt_q) == N_LOG - 1) begin
          stage_cnt_d = '0;
          out_code_d  = x_d;
          out_valid_d = 1'b1;
          state_d     = ST_OUTPUT;
`ifdef BPSK_MAP_EN
          for (int j = 0; j < N; j++) begin
            out_sym_d[j*BIT_N +: BIT_N] = x_d[j] ? SYM_NEG : SYM_POS;
          end
`endif
        end else begin
          stage_cnt_d = stage_cnt_q + SW'(1);
        end
      end
      ST_OUTPUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          x_d         = '0;
          info_cnt_d  = '0;
          stage_cnt_d = '0;
          state_d     = ST_LOAD;
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_LOAD;
      info_cnt_q  <= '0;
      stage_cnt_q <= '0;
      x_q         <= '0;
      out_code_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      info_cnt_q  <= info_cnt_d;
      stage_cnt_q <= stage_cnt_d;
      x_q         <= x_d;
      out_code_q  <= out_code_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef BPSK_MAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_sym_q <= '0;
    else        out_sym_q <= out_sym_d;
  end
  assign out_sym = out_sym_q;
`endif

  assign in_ready  = (state_q == ST_LOAD);
  assign busy      = (state_q != ST_LOAD);
  assign out_valid = out_valid_q;
  assign out_code  = out_code_q;

endmodule

// File: tb/tb_polar_encoder.sv
// Directed testbench for polar_encoder (default N=8, K=4, info set {3,5,6,7}).
// Define BPSK_MAP_EN to also check out_sym.
module tb_polar_encoder;

  localparam int N = 8;
  localparam int K = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic         in_bit;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_code;
  logic         busy;
`ifdef BPSK_MAP_EN
  logic [N*8-1:0] out_sym;
`endif

  polar_encoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bit    (in_bit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_code  (out_code),
`ifdef BPSK_MAP_EN
    .out_sym   (out_sym),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // info[b] is the b-th bit fed; it lands on unfrozen index 3,5,6,7 for b = 0..3.
  typedef struct {
    string        name;
    logic [K-1:0] info;
    logic [N-1:0] exp_code;
  } vec_t;

  vec_t vecs[7];

  task automatic send_frame(input logic [K-1:0] info);
    for (int b = 0; b < K; b++) begin
      in_valid = 1'b1;
      in_bit   = info[b];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_bit   = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic handshake(input string name);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({name, " valid_drop"}, 64'(out_valid), 64'd0);
    check({name, " ready_back"}, 64'(in_ready), 64'd1);
  endtask

  task automatic run_frame(input string name, input logic [K-1:0] info, input logic [N-1:0] exp_code);
    int cyc;
    send_frame(info);
    wait_valid(cyc);
    check({name, " latency"}, 64'(cyc), 64'd3);
    check({name, " code"}, 64'(out_code), 64'(exp_code));
    handshake(name);
  endtask

  initial begin
    int cyc;
    int accepted;
    logic [N-1:0] held;
    logic seen_valid;

    vecs[0] = '{"u3",      4'b0001, 8'h0F};
    vecs[1] = '{"u5",      4'b0010, 8'h33};
    vecs[2] = '{"u6",      4'b0100, 8'h55};
    vecs[3] = '{"u7",      4'b1000, 8'hFF};
    vecs[4] = '{"all_one", 4'b1111, 8'h96};
    vecs[5] = '{"u3_u5",   4'b0011, 8'h3C};
    vecs[6] = '{"zero",    4'b0000, 8'h00};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_bit    = 1'b0;
    out_ready = 1'b0;
    #12;
    check("rst in_ready",  64'(in_ready),  64'd1);
    check("rst out_valid", 64'(out_valid), 64'd0);
    check("rst out_code",  64'(out_code),  64'd0);
    check("rst busy",      64'(busy),      64'd0);
`ifdef BPSK_MAP_EN
    check("rst out_sym",   out_sym,        64'd0);
`endif
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 7; v++) begin
      run_frame(vecs[v].name, vecs[v].info, vecs[v].exp_code);
    end

`ifdef BPSK_MAP_EN
    send_frame(4'b0001);
    wait_valid(cyc);
    check("bpsk latency", 64'(cyc), 64'd3);
    check("bpsk code", 64'(out_code), 64'h0F);
    check("bpsk sym", out_sym, 64'h40404040_C0C0C0C0);
    handshake("bpsk");
`endif

    // Back-pressure: codeword, in_ready and busy must hold while out_ready is low.
    send_frame(4'b1111);
    wait_valid(cyc);
    held = out_code;
    check("bp code", 64'(held), 64'h96);
    in_valid = 1'b1;
    in_bit   = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check("bp stable",   64'(out_code),  64'(held));
      check("bp valid",    64'(out_valid), 64'd1);
      check("bp in_ready", 64'(in_ready),  64'd0);
      check("bp busy",     64'(busy),      64'd1);
    end
    in_valid = 1'b0;
    handshake("bp");
    check("bp code_kept", 64'(out_code), 64'h96);
    check("bp busy_low",  64'(busy),     64'd0);

    // Input gaps: random in_valid, junk in_bit when not valid.
    accepted = 0;
    for (int c = 0; c < 200 && accepted < K; c++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_bit   = in_valid ? 1'b1 : 1'($urandom);
      if (in_valid && in_ready) accepted++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("gap accepted", 64'(accepted), 64'(K));
    // Keep driving junk during ENCODE; it must be ignored.
    in_valid = 1'b1;
    in_bit   = 1'b0;
    wait_valid(cyc);
    in_valid = 1'b0;
    check("gap latency", 64'(cyc), 64'd3);
    check("gap code", 64'(out_code), 64'h96);
    handshake("gap");

    // Reset after two accepts discards the partial frame.
    in_valid = 1'b1;
    in_bit   = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    check("mid rst in_ready", 64'(in_ready), 64'd1);
    check("mid rst code",     64'(out_code), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_frame("after mid rst", 4'b0001, 8'h0F);

    // Reset during ENCODE: no codeword appears, FSM back in LOAD.
    send_frame(4'b1111);
    @(posedge clk); #1;
    check("enc busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #2;
    check("enc rst busy",     64'(busy),     64'd0);
    check("enc rst in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    seen_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (out_valid) seen_valid = 1'b1;
    end
    check("enc rst no_valid", 64'(seen_valid), 64'd0);
    check("enc rst load",     64'(in_ready),   64'd1);
    run_frame("after enc rst", 4'b0010, 8'h33);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/polar_encoder.md
Name: polar_encoder

Overview:
- Systematic-free polar encoder producing the codewords that the BP decoder datapath consumes.
- Accepts K information bits serially over a valid/ready handshake and places them at the unfrozen positions of an N-bit u vector; frozen positions are forced to 0.
- Runs log2(N) XOR butterfly stages, one per clock, to compute x = u·F^{⊗n} in natural index order.
- Presents the N-bit codeword in parallel over a valid/ready handshake; also serves as the loopback stimulus source for the decoder.

Parameters:
- N_LOG, 3, log2 of code length; N = 2^N_LOG.
- K, 4, number of information bits per frame; must equal N minus popcount(FROZEN_MASK).
- FROZEN_MASK, 8'h17, N-bit mask; bit i = 1 means u[i] is frozen to 0. The default freezes indices {0,1,2,4}, so the info set is {3,5,6,7}.
- BIT_N, 8, symbol width in two's complement; used only when BPSK_MAP_EN is defined.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_bit is valid.
- in_ready  output  1  encoder accepts an info bit this cycle.
- in_bit  input  1  information bit.
- out_valid  output  1  out_code holds a complete codeword.
- out_ready  input  1  downstream accepts the codeword.
- out_code  output  N  codeword; bit j = x[j].
- busy  output  1  high in ENCODE and OUTPUT states.

Behaviour:
- Reset (rst_n low, asynchronous, any state including mid-frame or mid-encode):
  - state = LOAD, info counter = 0, stage counter = 0, u/x register = 0.
  - out_code = 0, out_valid = 0, in_ready = 1, busy = 0.
  - Any partial frame is discarded.
- FSM states: LOAD, ENCODE, OUTPUT.
- LOAD:
  - in_ready = 1.
  - Each cycle with in_valid & in_ready writes in_bit into the next unfrozen index in ascending order. The first accepted bit goes to the lowest unfrozen index.
  - Frozen indices stay 0 regardless of input.
  - Info counter runs 0..K-1. The accept at count K-1 moves the FSM to ENCODE on the next edge.
  - Cycles with in_valid low do not advance anything.
- ENCODE:
  - in_ready = 0; in_valid is ignored.
  - Stage counter s runs 0..N_LOG-1. Each cycle, for every i with bit s of i equal to 0: x[i] <= x[i] ^ x[i + 2^s].
  - After stage N_LOG-1: out_code <= x, out_valid <= 1, FSM moves to OUTPUT.
  - Result: x[j] = XOR of u[i] over all i whose bit set contains j's bit set.
- Latency: out_valid rises N_LOG clock edges after the edge that accepted the K-th info bit (3 cycles at default).
- OUTPUT:
  - out_valid = 1; out_code holds stable until out_ready = 1.
  - On out_valid & out_ready: out_valid <= 0, FSM moves to LOAD, counters clear, u/x register clears. in_ready is 1 the following cycle.
  - No overlap of frames: in_ready = 0 throughout OUTPUT, even if out_ready is held high.
- out_code keeps its last value after the handshake until the next codeword is loaded; only out_valid qualifies it.
- busy = (state != LOAD).

Optional Feature:
- Macro: BPSK_MAP_EN.
- Defined:
  - Adds output port out_sym, width N*BIT_N.
  - Symbol j sits at [j*BIT_N +: BIT_N]: x[j] = 0 gives +2^(BIT_N-2) (8'h40 at default); x[j] = 1 gives -2^(BIT_N-2) (8'hC0 at default).
  - out_sym is registered, updated on the same edge as out_code, held under the same out_valid/out_ready rules, and reset to all zero.
- Not defined: port and logic are absent; the rest of the behaviour is unchanged.

Test Plan:
- Reset state: after reset, check in_ready=1, out_valid=0, out_code=8'h00, busy=0. Feed info 1,0,0,0 (u[3]=1) with in_valid held high → out_valid 3 cycles after the 4th accept, out_code=8'h0F.
- Single info bits: info 0,1,0,0 → out_code=8'h33. Info 0,0,0,1 → out_code=8'hFF. Info 1,1,1,1 → out_code=8'h96.
- Back-pressure: hold out_ready=0 for 10 cycles after out_valid → out_code stable, in_ready=0, busy=1. Raise out_ready for 1 cycle → next cycle out_valid=0, in_ready=1.
- Input gaps: toggle in_valid randomly and drive in_bit while in_ready=0 → only handshaked bits are used; result matches the gap-free case (8'h96 for all-ones info).
- Reset mid-operation:
  - Assert rst_n low after 2 accepts → frame discarded. A fresh 1,0,0,0 frame gives 8'h0F.
  - Assert rst_n low during ENCODE → out_valid never rises; the FSM is back in LOAD.
- With BPSK_MAP_EN, info 1,0,0,0 → out_sym symbols 0–3 = 8'hC0, symbols 4–7 = 8'h40, timed with out_code.
